weight_config_sender: RTL and testbench

Transmit side of the neuron weight-configuration bus. It takes a flow-controlled stream of 32-bit pretrained weight words and broadcasts them as `weight_valid` / `weight_value` beats. Each beat is tagged with `config_layer_no` / `config_neuron_no`, so that only the addressed neuron captures the word. One configuration run loads every neuron of one layer, in order neuron 0..N-1, each receiving exactly `cfg_num_weights` consecutive words. The block sits between the host/DMA weight source and the layer's neuron array.

---
 rtl/weight_config_sender.sv | 125 ++++++++++++
 tb/tb_weight_config_sender.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/weight_config_sender.sv
// Weight-configuration bus transmitter: streams a layer's weight words to its
// neurons, one neuron at a time, each beat tagged with layer and neuron number.
module weight_config_sender #(
  parameter int max_neurons = 30,
  parameter int max_weights = 784
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] cfg_layer,
  input  logic [31:0] cfg_num_neurons,
  input  logic [31:0] cfg_num_weights,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  output logic        weight_valid,
  output logic [31:0] weight_value,
  output logic [31:0] config_layer_no,
  output logic [31:0] config_neuron_no,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam int NW = $clog2(max_neurons + 1);
  localparam int WW = $clog2(max_weights + 1);
  localparam logic [NW-1:0] one_n = 1;
  localparam logic [WW-1:0] one_w = 1;

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  state_t          state_reg, state_next;
  logic [31:0]     layer_reg;
  logic [NW-1:0]   num_neurons_reg;
  logic [WW-1:0]   num_weights_reg;
  logic [NW-1:0]   neuron_cnt_reg;
  logic [WW-1:0]   weight_cnt_reg;
  logic            error_reg;
  logic            cfg_legal;
  logic            start_ok;
  logic            start_bad;
  logic            handshake;
  logic            weight_last;
  logic            run_last;

  assign cfg_legal = (cfg_num_neurons != 32'd0) && (cfg_num_neurons <= 32'(max_neurons)) &&
                     (cfg_num_weights != 32'd0) && (cfg_num_weights <= 32'(max_weights));

  assign weight_last = (weight_cnt_reg == num_weights_reg - one_w);
  assign run_last    = weight_last && (neuron_cnt_reg == num_neurons_reg - one_n);
  assign error       = error_reg;

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    start_ok   = 1'b0;
    start_bad  = 1'b0;
    handshake  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          start_ok  = cfg_legal;
          start_bad = !cfg_legal;
          if (cfg_legal) state_next = SEND;
        end
      end
      SEND: begin
        in_ready  = 1'b1;
        busy      = 1'b1;
        handshake = in_valid;
        if (in_valid && run_last) state_next = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      layer_reg        <= '0;
      num_neurons_reg  <= '0;
      num_weights_reg  <= '0;
      neuron_cnt_reg   <= '0;
      weight_cnt_reg   <= '0;
      error_reg        <= 1'b0;
      weight_valid     <= 1'b0;
      weight_value     <= '0;
      config_layer_no  <= '0;
      config_neuron_no <= '0;
    end else begin
      error_reg    <= start_bad;
      weight_valid <= handshake;
      if (start_ok) begin
        layer_reg       <= cfg_layer;
        num_neurons_reg <= cfg_num_neurons[NW-1:0];
        num_weights_reg <= cfg_num_weights[WW-1:0];
        neuron_cnt_reg  <= '0;
        weight_cnt_reg  <= '0;
      end
      if (handshake) begin
        weight_value     <= in_data;
        config_layer_no  <= layer_reg;
        config_neuron_no <= {{(32-NW){1'b0}}, neuron_cnt_reg};
        if (weight_last) begin
          weight_cnt_reg <= '0;
          neuron_cnt_reg <= neuron_cnt_reg + one_n;
        end else begin
          weight_cnt_reg <= weight_cnt_reg + one_w;
        end
      end
    end
  end

endmodule

// File: tb/tb_weight_config_sender.sv
// Directed bench for weight_config_sender: normal runs, stalls, illegal and
// redundant starts, mid-run reset and a maximum-length neuron.
module tb_weight_config_sender;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [31:0] cfg_layer = '0;
  logic [31:0] cfg_num_neurons = '0;
  logic [31:0] cfg_num_weights = '0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_ready;
  logic        weight_valid;
  logic [31:0] weight_value;
  logic [31:0] config_layer_no;
  logic [31:0] config_neuron_no;
  logic        busy;
  logic        done;
  logic        error;

  int checks = 0;
  int failures = 0;

  weight_config_sender #(.max_neurons(30), .max_weights(784)) dut (
    .clk(clk), .reset(reset), .start(start),
    .cfg_layer(cfg_layer), .cfg_num_neurons(cfg_num_neurons), .cfg_num_weights(cfg_num_weights),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .weight_valid(weight_valid), .weight_value(weight_value),
    .config_layer_no(config_layer_no), .config_neuron_no(config_neuron_no),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, in_ready, 0);
    check({tag, "_valid"}, weight_valid, 0);
    check({tag, "_value"}, weight_value, 0);
    check({tag, "_layer"}, config_layer_no, 0);
    check({tag, "_neuron"}, config_neuron_no, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_error"}, error, 0);
  endtask

  task automatic illegal_start(input string tag, input int n, input int w);
    start = 1'b1; cfg_layer = 32'd5; cfg_num_neurons = n; cfg_num_weights = w;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_error"}, error, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_valid"}, weight_valid, 0);
    check({tag, "_value"}, weight_value, 0);
    @(posedge clk); #1;
    check({tag, "_error_pulse"}, error, 0);
    check({tag, "_busy2"}, busy, 0);
    $display("illegal start %s n=%0d w=%0d", tag, n, w);
  endtask

  // Runs one configuration; bench tracks beat index k and expects each
  // accepted word one cycle later with tags derived from k.
  task automatic do_run(input string tag, input logic [31:0] layer, input int n, input int w,
                        input logic [31:0] base, input bit stall, input int mid_start_at,
                        input int abort_at);
    int k = 0;
    int c = 0;
    bit hs;
    start = 1'b1; cfg_layer = layer; cfg_num_neurons = n; cfg_num_weights = w; in_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_start_busy"}, busy, 1);
    check({tag, "_start_ready"}, in_ready, 1);
    while (k < n * w) begin
      in_valid = stall ? (c % 3 == 0) : 1'b1;
      in_data  = base + k;
      if (mid_start_at == k) begin
        start = 1'b1; cfg_layer = 32'd7; cfg_num_neurons = 1; cfg_num_weights = 1;
      end
      hs = in_valid;
      @(posedge clk); #1;
      start = 1'b0;
      if (hs) begin
        check({tag, "_valid"}, weight_valid, 1);
        check({tag, "_value"}, weight_value, base + k);
        check({tag, "_neuron"}, config_neuron_no, k / w);
        check({tag, "_layer"}, config_layer_no, layer);
        k++;
        check({tag, "_done"}, done, (k == n * w) ? 1 : 0);
        $display("%s beat %0d value=%h neuron=%0d layer=%0d", tag, k - 1, weight_value,
                 config_neuron_no, config_layer_no);
      end else begin
        check({tag, "_gap_valid"}, weight_valid, 0);
        if (k > 0) check({tag, "_gap_hold"}, weight_value, base + k - 1);
      end
      if (hs && abort_at == k) begin
        reset = 1'b0; in_valid = 1'b0;
        #1;
        check_all_zero({tag, "_abort"});
        @(posedge clk); #1;
        check_all_zero({tag, "_abort2"});
        @(negedge clk);
        reset = 1'b1;
        $display("%s reset after beat %0d", tag, k);
        return;
      end
      c++;
      check({tag, "_ready"}, in_ready, (k < n * w) ? 1 : 0);
    end
    in_valid = 1'b0;
    check({tag, "_busy_done"}, busy, 1);
    @(posedge clk); #1;
    check({tag, "_end_busy"}, busy, 0);
    check({tag, "_end_done"}, done, 0);
    check({tag, "_end_valid"}, weight_valid, 0);
    check({tag, "_end_hold"}, weight_value, base + n * w - 1);
    check({tag, "_end_neuron"}, config_neuron_no, n - 1);
    $display("%s complete n=%0d w=%0d", tag, n, w);
  endtask

  initial begin
    #12;
    check_all_zero("reset");
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check_all_zero("post_reset");
    $display("reset released");

    illegal_start("zero_weights", 3, 0);
    illegal_start("too_many_neurons", 31, 4);

    do_run("basic", 32'd2, 3, 4, 32'h100, 1'b0, -1, -1);
    do_run("stall", 32'd3, 1, 5, 32'h200, 1'b1, -1, -1);
    do_run("busy_start", 32'd4, 3, 4, 32'h300, 1'b0, 5, -1);
    do_run("abort", 32'd2, 3, 4, 32'h400, 1'b0, -1, 6);
    do_run("after_abort", 32'd2, 3, 4, 32'h500, 1'b0, -1, -1);
    do_run("max", 32'd9, 1, 784, 32'hA000_0000, 1'b0, -1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
